// File: rtl/psram_port_arbiter.sv
// psram_port_arbiter: round-robin arbiter that shares one PSRAM controller among
// NUM_PORTS user ports. Each port asks for a single burst (address, length,
// direction). The arbiter latches the winner's command, strobes psram_exe for one
// cycle, forwards data strobes to the granted port, and returns a done pulse, or an
// err pulse on an illegal length or a BUSY timeout.
//
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   port_req/rw/addr/len/wdata  per-port request; port i sits at slice i
//   port_grant                one-hot grant of the port being served
//   port_wr_valid/rd_valid    controller data strobes routed to the granted port
//   port_rd_data              controller read data, broadcast to all ports
//   port_done/port_err        one-cycle completion / reject-or-timeout pulses
//   init_cable_complete       controller calibration finished
//   psram_exe, rw_ctrl, addr_in, burst_len, data_in   command to the controller
//   psram_done, psram_rd_data, psram_rd_valid, psram_wr_valid  controller status
module psram_port_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEN_W       = 12,
  parameter int unsigned MAX_LEN     = 1024,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  port_len,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_grant,
  output logic [NUM_PORTS-1:0]        port_wr_valid,
  output logic [NUM_PORTS-1:0]        port_rd_valid,
  output logic [DATA_W-1:0]           port_rd_data,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [NUM_PORTS-1:0]        port_err,
  input  logic                        init_cable_complete,
  output logic                        psram_exe,
  output logic                        rw_ctrl,
  output logic [ADDR_W-1:0]           addr_in,
  output logic [LEN_W-1:0]            burst_len,
  output logic [DATA_W-1:0]           data_in,
  input  logic                        psram_done,
  input  logic [DATA_W-1:0]           psram_rd_data,
  input  logic                        psram_rd_valid,
  input  logic                        psram_wr_valid
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {StInit, StArb, StIssue, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, gidx_q;
  logic [NUM_PORTS-1:0]   grant_q, done_q, err_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LEN_W-1:0]       len_q;
  logic                   rw_q;
  logic [31:0]            cnt_q;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_PORTS-1:0]   win_onehot;
  logic [LEN_W-1:0]       win_len;
  logic                   len_ok;
  logic                   timeout_hit;
  logic                   busy_end;

  // Wraps to 0 after the last port; with a single port this always yields 0.
  function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
    if (32'(p) >= NUM_PORTS - 1) return '0;
    return p + 1'b1;
  endfunction

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!win_found && port_req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_onehot  = NUM_PORTS'(1) << win_idx;
  assign win_len     = port_len[win_idx*LEN_W +: LEN_W];
  assign len_ok      = (win_len != '0) && (32'(win_len) <= MAX_LEN);
  // Counter starts at 0 on the first BUSY cycle, so this fires on BUSY cycle TIMEOUT_CYC.
  assign timeout_hit = (cnt_q >= TIMEOUT_CYC - 1);
  // psram_done wins over a simultaneous timeout.
  assign busy_end    = (state_q == StBusy) && (psram_done || timeout_hit);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= StInit;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:  if (init_cable_complete) state_d = StArb;
      StArb: begin
        if (!init_cable_complete)    state_d = StInit;
        else if (win_found && len_ok) state_d = StIssue;
      end
      StIssue: state_d = StBusy;
      StBusy:  if (busy_end) state_d = init_cable_complete ? StArb : StInit;
      default: state_d = StInit;
    endcase
  end

  // Output logic
  always_comb begin
    psram_exe     = (state_q == StIssue);
    data_in       = '0;
    port_wr_valid = '0;
    port_rd_valid = '0;
    if (state_q == StBusy) begin
      data_in       = port_wdata[gidx_q*DATA_W +: DATA_W];
      port_wr_valid = grant_q & {NUM_PORTS{psram_wr_valid}};
      port_rd_valid = grant_q & {NUM_PORTS{psram_rd_valid}};
    end
  end

  // Command latch, grant, pulses, round-robin pointer and BUSY counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        StArb: begin
          if (init_cable_complete && win_found) begin
            if (len_ok) begin
              grant_q <= win_onehot;
              gidx_q  <= win_idx;
              addr_q  <= port_addr[win_idx*ADDR_W +: ADDR_W];
              len_q   <= win_len;
              rw_q    <= port_rw[win_idx];
            end else begin
              err_q    <= win_onehot;
              rr_ptr_q <= inc_ptr(win_idx);
            end
          end
        end
        StIssue: cnt_q <= '0;
        StBusy: begin
          if (busy_end) begin
            if (psram_done) done_q <= grant_q;
            else            err_q  <= grant_q;
            grant_q  <= '0;
            rr_ptr_q <= inc_ptr(gidx_q);
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign port_grant   = grant_q;
  assign port_done    = done_q;
  assign port_err     = err_q;
  assign port_rd_data = psram_rd_data;
  assign rw_ctrl      = rw_q;
  assign addr_in      = addr_q;
  assign burst_len    = len_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed testbench for psram_port_arbiter (4 ports, 100-cycle BUSY timeout).
module tb_psram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LW = 12;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic [NP-1:0]    port_req;
  logic [NP-1:0]    port_rw;
  logic [NP*AW-1:0] port_addr;
  logic [NP*LW-1:0] port_len;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_grant, port_wr_valid, port_rd_valid, port_done, port_err;
  logic [DW-1:0]    port_rd_data;
  logic             init_cable_complete;
  logic             psram_exe, rw_ctrl;
  logic [AW-1:0]    addr_in;
  logic [LW-1:0]    burst_len;
  logic [DW-1:0]    data_in;
  logic             psram_done;
  logic [DW-1:0]    psram_rd_data;
  logic             psram_rd_valid, psram_wr_valid;

  int tests = 0;
  int fails = 0;

  psram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
    .MAX_LEN(1024), .TIMEOUT_CYC(100)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .port_req(port_req), .port_rw(port_rw), .port_addr(port_addr),
    .port_len(port_len), .port_wdata(port_wdata),
    .port_grant(port_grant), .port_wr_valid(port_wr_valid),
    .port_rd_valid(port_rd_valid), .port_rd_data(port_rd_data),
    .port_done(port_done), .port_err(port_err),
    .init_cable_complete(init_cable_complete),
    .psram_exe(psram_exe), .rw_ctrl(rw_ctrl), .addr_in(addr_in),
    .burst_len(burst_len), .data_in(data_in),
    .psram_done(psram_done), .psram_rd_data(psram_rd_data),
    .psram_rd_valid(psram_rd_valid), .psram_wr_valid(psram_wr_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the command strobe.
  task automatic wait_exe(input string tag);
    int n = 0;
    while (psram_exe !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check(tag, psram_exe, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP-1:0] exp_order [5];
    int            saw;
    int            strobes;

    sys_rst = 1'b1; port_req = '0; port_rw = '0; port_addr = '0; port_len = '0;
    port_wdata = '0; init_cable_complete = 1'b0; psram_done = 1'b0;
    psram_rd_data = '0; psram_rd_valid = 1'b0; psram_wr_valid = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_grant", port_grant, 4'b0000);
    check("rst_exe", psram_exe, 1'b0);
    check("rst_addr", addr_in, 32'h0);
    check("rst_len", burst_len, 12'h0);
    check("rst_done_err", {port_done, port_err}, 8'h00);

    // No command while calibration is pending; then N+1 grant timing
    sys_rst = 1'b0;
    port_req = 4'b0001; port_rw[0] = 1'b1;
    port_addr[0*AW +: AW] = 32'h0000_0100; port_len[0*LW +: LW] = 12'd4;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (psram_exe === 1'b1) saw++;
    end
    check("no_exe_before_init", saw, 0);
    init_cable_complete = 1'b1;
    tick();  // INIT -> ARB
    check("exe_after_init_arb", psram_exe, 1'b0);
    tick();  // ARB sampled request -> ISSUE
    check("init_exe", psram_exe, 1'b1);
    check("init_grant", port_grant, 4'b0001);
    check("init_addr", addr_in, 32'h0000_0100);
    check("init_len", burst_len, 12'd4);
    check("init_rw", rw_ctrl, 1'b1);
    tick();  // BUSY
    check("exe_one_cycle", psram_exe, 1'b0);
    check("busy_grant_held", port_grant, 4'b0001);
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0; port_req = '0;
    check("init_done_pulse", port_done, 4'b0001);
    check("init_grant_clr", port_grant, 4'b0000);
    tick();
    check("done_one_cycle", port_done, 4'b0000);

    // Round robin with all four ports requesting; pointer restarts at 0 after reset
    sys_rst = 1'b1;
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < NP; i++) begin
      port_addr[i*AW +: AW] = 32'h1000 * (i + 1);
      port_len[i*LW +: LW]  = LW'(i + 1);
    end
    port_rw  = 4'b1111;
    port_req = 4'b1111;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      wait_exe($sformatf("rr_exe%0d", t));
      check($sformatf("rr_grant%0d", t), port_grant, exp_order[t]);
      for (int c = 0; c < 19; c++) tick();
      check($sformatf("rr_held%0d", t), port_grant, exp_order[t]);
      psram_done = 1'b1;
      tick();
      psram_done = 1'b0;
      if (t == 4) port_req = '0;
      check($sformatf("rr_done%0d", t), port_done, exp_order[t]);
    end
    check("rr_addr_last", addr_in, 32'h1000);

    // Port 2 write burst of 8; rr_ptr is now 1
    port_rw = 4'b0000;
    port_len[2*LW +: LW] = 12'd8;
    port_addr[2*AW +: AW] = 32'hCAFE_0000;
    port_wdata = {16'h3333, 16'hAAAA, 16'h1111, 16'h0000};
    port_req = 4'b0100;
    tick();
    wait_exe("wr_exe");
    check("wr_grant", port_grant, 4'b0100);
    check("wr_len", burst_len, 12'd8);
    check("wr_rw", rw_ctrl, 1'b0);
    port_req = 4'b0000;  // dropping request must not abort the burst
    tick();
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      psram_wr_valid = (i % 3 != 2);
      port_wdata[2*DW +: DW] = 16'h1000 + 16'(i);
      #1;
      if (data_in !== 16'h1000 + 16'(i)) check($sformatf("wr_data%0d", i), data_in,
                                               16'h1000 + 16'(i));
      if (port_wr_valid !== (psram_wr_valid ? 4'b0100 : 4'b0000))
        check($sformatf("wr_valid%0d", i), port_wr_valid, psram_wr_valid ? 4'b0100 : 4'b0000);
      if (port_wr_valid[2] === 1'b1) strobes++;
      tick();
    end
    check("wr_data_follow", data_in, 16'h100B);
    check("wr_strobes", strobes, 8);
    psram_wr_valid = 1'b0;
    psram_rd_valid = 1'b1; psram_rd_data = 16'hBEEF;
    #1;
    check("rd_valid_route", port_rd_valid, 4'b0100);
    check("rd_data_bcast", port_rd_data, 16'hBEEF);
    psram_rd_valid = 1'b0;
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    check("wr_done", port_done, 4'b0100);
    check("wr_valid_idle", port_wr_valid, 4'b0000);

    // Port 1 illegal lengths 0 and 1025; rr_ptr is now 3
    port_len[1*LW +: LW] = 12'd0;
    port_req = 4'b0010;
    tick();
    check("len0_err", port_err, 4'b0010);
    check("len0_noexe", psram_exe, 1'b0);
    port_len[1*LW +: LW] = 12'd1025;
    tick();
    check("len1025_err", port_err, 4'b0010);
    check("len1025_noexe", psram_exe, 1'b0);
    port_req = '0;
    tick();
    check("err_one_cycle", port_err, 4'b0000);

    // psram_done outside BUSY is ignored
    psram_done = 1'b1;
    tick();
    psram_done = 1'b0;
    check("stray_done", {port_done, port_err, port_grant}, 12'h000);

    // rr_ptr=2 makes port 2 beat port 1; then withhold done to hit the timeout
    port_len[1*LW +: LW] = 12'd2;
    port_req = 4'b0110;
    tick();
    wait_exe("to_exe");
    check("rr_ptr_after_err", port_grant, 4'b0100);
    port_req = '0;
    tick();  // first BUSY cycle
    saw = 0;
    for (int c = 1; c < 100; c++) begin
      tick();
      if (port_err !== 4'b0000 || port_done !== 4'b0000) saw++;
    end
    check("to_early", saw, 0);
    check("to_grant_held", port_grant, 4'b0100);
    tick();
    check("to_err", port_err, 4'b0100);
    check("to_no_done", port_done, 4'b0000);
    check("to_grant_clr", port_grant, 4'b0000);

    // Reset mid-BUSY; rr_ptr=3 so port 0 is found by wrapping
    port_req = 4'b0001;
    tick();
    wait_exe("rst_exe");
    check("rst_pre_grant", port_grant, 4'b0001);
    tick(); tick();
    sys_rst = 1'b1;
    #1;
    check("midrst_grant", port_grant, 4'b0000);
    check("midrst_cmd", {psram_exe, rw_ctrl, addr_in, burst_len}, 46'h0);
    check("midrst_pulses", {port_done, port_err}, 8'h00);
    init_cable_complete = 1'b0;
    tick();
    sys_rst = 1'b0;
    port_req = 4'b1001;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (psram_exe === 1'b1 || port_done !== 4'b0000 || port_err !== 4'b0000) saw++;
    end
    check("midrst_quiet", saw, 0);
    init_cable_complete = 1'b1;
    tick();
    wait_exe("restart_exe");
    check("restart_port0", port_grant, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
